// File: rtl/nx_stream_distributor.sv
// nx_stream_distributor: one inbound message stream steered to four outbound
// streams (N/E/S/W) by column-first dimension-ordered routing, with a small
// FIFO per direction. Self-addressed messages are discarded and flagged.
// Optional per-direction sent counters: define NX_STREAM_DISTRIBUTOR_COUNT_EN.

package nx_stream_distributor_pkg;
    localparam int unsigned COORD_WIDTH   = 4;
    localparam int unsigned PAYLOAD_WIDTH = 24;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] row;
        logic [COORD_WIDTH-1:0] column;
    } node_header_t;

    typedef struct packed {
        node_header_t             header;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } node_message_t;

    localparam int unsigned MESSAGE_WIDTH = $bits(node_message_t);

    localparam logic [1:0] DIRECTION_NORTH = 2'd0;
    localparam logic [1:0] DIRECTION_EAST  = 2'd1;
    localparam logic [1:0] DIRECTION_SOUTH = 2'd2;
    localparam logic [1:0] DIRECTION_WEST  = 2'd3;
endpackage

module nx_stream_distributor
    import nx_stream_distributor_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [COORD_WIDTH-1:0]        i_node_row,
    input  logic [COORD_WIDTH-1:0]        i_node_column,
    input  node_message_t                 i_inbound_data,
    input  logic                          i_inbound_valid,
    output logic                          o_inbound_ready,
    output logic [3:0][MESSAGE_WIDTH-1:0] o_outbound_data,
    output logic [3:0]                    o_outbound_valid,
    input  logic [3:0]                    i_outbound_ready,
    output logic                          o_self_drop
`ifdef NX_STREAM_DISTRIBUTOR_COUNT_EN
    ,
    output logic [3:0][15:0]              o_sent_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [MESSAGE_WIDTH-1:0] mem    [4][DEPTH];
    logic [PW-1:0]            wr_ptr [4];
    logic [PW-1:0]            rd_ptr [4];
    logic [3:0]               full;
    logic [3:0]               empty;
    logic [3:0]               push;
    logic [3:0]               pop;
    logic [1:0]               target;
    logic                     self_addr;
    logic                     accept;

    // Column-first routing decision for the inbound header
    always_comb begin
        target    = DIRECTION_NORTH;
        self_addr = 1'b0;
        if (i_inbound_data.header.column > i_node_column) begin
            target = DIRECTION_EAST;
        end else if (i_inbound_data.header.column < i_node_column) begin
            target = DIRECTION_WEST;
        end else if (i_inbound_data.header.row > i_node_row) begin
            target = DIRECTION_SOUTH;
        end else if (i_inbound_data.header.row < i_node_row) begin
            target = DIRECTION_NORTH;
        end else begin
            self_addr = 1'b1;
        end
    end

    // FIFO status, output presentation and pop decode
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            empty[d]            = (wr_ptr[d] == rd_ptr[d]);
            full[d]             = (wr_ptr[d][AW-1:0] == rd_ptr[d][AW-1:0]) &&
                                  (wr_ptr[d][AW] != rd_ptr[d][AW]);
            pop[d]              = !empty[d] && i_outbound_ready[d];
            o_outbound_valid[d] = !empty[d];
            o_outbound_data[d]  = mem[d][rd_ptr[d][AW-1:0]];
        end
    end

    // Inbound handshake: a same-cycle pop frees the slot of a full target FIFO
    always_comb begin
        o_inbound_ready = self_addr || !full[target] || pop[target];
        accept          = i_inbound_valid && o_inbound_ready;
        for (int d = 0; d < 4; d++) begin
            push[d] = accept && !self_addr && (target == 2'(d));
        end
    end

    // FIFO storage, deliberately not reset
    always_ff @(posedge i_clk) begin
        for (int d = 0; d < 4; d++) begin
            if (push[d]) begin
                mem[d][wr_ptr[d][AW-1:0]] <= i_inbound_data;
            end
        end
    end

    // FIFO pointers; reset discards everything queued
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int d = 0; d < 4; d++) begin
                wr_ptr[d] <= '0;
                rd_ptr[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (push[d]) wr_ptr[d] <= wr_ptr[d] + PW'(1);
                if (pop[d])  rd_ptr[d] <= rd_ptr[d] + PW'(1);
            end
        end
    end

    // Sticky flag for discarded self-addressed messages
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_self_drop <= 1'b0;
        end else if (accept && self_addr) begin
            o_self_drop <= 1'b1;
        end
    end

`ifdef NX_STREAM_DISTRIBUTOR_COUNT_EN
    // Per-direction output handshake counters, wrapping at 16 bits
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_sent_count <= '0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (pop[d]) o_sent_count[d] <= o_sent_count[d] + 16'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_nx_stream_distributor.sv
// Self-checking bench for nx_stream_distributor: queue-based reference model,
// directed scenarios with literal pins, then randomized traffic.
module tb_nx_stream_distributor;
    import nx_stream_distributor_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic                          clk;
    logic                          rst;
    logic [COORD_WIDTH-1:0]        node_row;
    logic [COORD_WIDTH-1:0]        node_col;
    node_message_t                 in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [3:0][MESSAGE_WIDTH-1:0] out_data;
    logic [3:0]                    out_valid;
    logic [3:0]                    out_ready;
    logic                          self_drop;
`ifdef NX_STREAM_DISTRIBUTOR_COUNT_EN
    logic [3:0][15:0]              sent_count;
`endif

    nx_stream_distributor #(.DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_node_row       (node_row),
        .i_node_column    (node_col),
        .i_inbound_data   (in_data),
        .i_inbound_valid  (in_valid),
        .o_inbound_ready  (in_ready),
        .o_outbound_data  (out_data),
        .o_outbound_valid (out_valid),
        .i_outbound_ready (out_ready),
        .o_self_drop      (self_drop)
`ifdef NX_STREAM_DISTRIBUTOR_COUNT_EN
        ,
        .o_sent_count     (sent_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    node_message_t q [4][$];
    bit            m_drop;
    logic [15:0]   m_cnt [4];
    bit            m_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic node_message_t mk(input int r, input int c, input logic [23:0] p);
        node_message_t m;
        m.header.row    = COORD_WIDTH'(r);
        m.header.column = COORD_WIDTH'(c);
        m.payload       = p;
        return m;
    endfunction

    // 0..3 = N/E/S/W, 4 = self-addressed
    function automatic int route(input node_message_t m);
        if (m.header.column > node_col) return 1;
        if (m.header.column < node_col) return 3;
        if (m.header.row > node_row)    return 2;
        if (m.header.row < node_row)    return 0;
        return 4;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 4; d++) begin
            q[d].delete();
            m_cnt[d] = '0;
        end
        m_drop = 1'b0;
    endtask

    // Compare every observable output against the model for the current inputs
    task automatic compare_model();
        int dir;
        int free_after_pop;
        dir = route(in_data);
        if (dir == 4) begin
            m_rdy = 1'b1;
        end else begin
            free_after_pop = DEPTH - q[dir].size() + ((q[dir].size() > 0 && out_ready[dir]) ? 1 : 0);
            m_rdy = (free_after_pop > 0);
        end
        chk("inbound_ready", 64'(in_ready), 64'(m_rdy));
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("valid[%0d]", d), 64'(out_valid[d]), 64'(q[d].size() > 0));
            if (q[d].size() > 0)
                chk($sformatf("data[%0d]", d), 64'(out_data[d]), 64'(q[d][0]));
`ifdef NX_STREAM_DISTRIBUTOR_COUNT_EN
            chk($sformatf("count[%0d]", d), 64'(sent_count[d]), 64'(m_cnt[d]));
`endif
        end
        chk("self_drop", 64'(self_drop), 64'(m_drop));
    endtask

    task automatic advance_model();
        int dir;
        dir = route(in_data);
        for (int d = 0; d < 4; d++) begin
            if (q[d].size() > 0 && out_ready[d]) begin
                void'(q[d].pop_front());
                m_cnt[d] = m_cnt[d] + 16'd1;
            end
        end
        if (in_valid && m_rdy) begin
            if (dir == 4) m_drop = 1'b1;
            else          q[dir].push_back(in_data);
        end
    endtask

    // One clock cycle: drive at negedge, check, then advance model at posedge
    task automatic step(input logic v, input node_message_t m, input logic [3:0] ordy, input int lit_rdy);
        @(negedge clk);
        in_valid  = v;
        in_data   = m;
        out_ready = ordy;
        #1;
        compare_model();
        if (lit_rdy >= 0) chk("ready_literal", 64'(in_ready), 64'(lit_rdy));
        @(posedge clk);
        advance_model();
    endtask

    task automatic idle(input int n, input logic [3:0] ordy);
        for (int i = 0; i < n; i++) step(1'b0, mk(0, 0, 24'h0), ordy, -1);
    endtask

    node_message_t ma, mb, mc, ms;

    initial begin
        rst       = 1'b0;
        node_row  = 4'd2;
        node_col  = 4'd2;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'hF;
        model_clear();
        m_rdy = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(out_valid), 64'h0);
        chk("reset_ready", 64'(in_ready), 64'h1);
        chk("reset_drop",  64'(self_drop), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Pin the routing model itself
        chk("route_east",  64'(route(mk(2, 5, 24'h0))), 64'd1);
        chk("route_west",  64'(route(mk(2, 0, 24'h0))), 64'd3);
        chk("route_south", 64'(route(mk(4, 2, 24'h0))), 64'd2);
        chk("route_north", 64'(route(mk(0, 2, 24'h0))), 64'd0);
        chk("route_diag",  64'(route(mk(0, 5, 24'h0))), 64'd1);

        // One message per direction, visible one cycle after acceptance
        step(1'b1, mk(2, 5, 24'hE0E0E0), 4'h0, 1);
        #1;
        chk("east_valid_lit", 64'(out_valid), 64'b0010);
        chk("east_data_lit",  64'(out_data[1]), 64'h25E0E0E0);
        step(1'b1, mk(2, 0, 24'h111111), 4'hF, 1);
        step(1'b1, mk(4, 2, 24'h222222), 4'hF, 1);
        step(1'b1, mk(0, 2, 24'h333333), 4'hF, 1);
        idle(3, 4'hF);

        // Diagonal goes column-first
        step(1'b1, mk(0, 5, 24'hABCDEF), 4'h0, 1);
        #1;
        chk("diag_valid_lit", 64'(out_valid), 64'b0010);
        idle(2, 4'hF);

        // EAST stalled: fill, back-pressure, bypass SOUTH, then push+pop on full
        ma = mk(2, 6, 24'h00000A);
        mb = mk(2, 7, 24'h00000B);
        mc = mk(3, 4, 24'h00000C);
        ms = mk(5, 2, 24'h00005A);
        step(1'b1, ma, 4'b1101, 1);
        step(1'b1, mb, 4'b1101, 1);
        step(1'b1, mc, 4'b1101, 0);
        step(1'b1, mc, 4'b1101, 0);
        step(1'b1, ms, 4'b1101, 1);
        step(1'b1, mc, 4'b1111, 1);
        #1;
        chk("fullpop_head_b", 64'(out_data[1]), 64'(mb));
        idle(3, 4'hF);

        // Self-addressed: consumed, nothing emitted, sticky flag
        step(1'b1, mk(2, 2, 24'h5E1F00), 4'hF, 1);
        #1;
        chk("self_drop_lit", 64'(self_drop), 64'h1);
        chk("self_none_lit", 64'(out_valid), 64'h0);
        idle(3, 4'hF);

        // Asynchronous reset with two WEST messages queued
        step(1'b1, mk(2, 1, 24'h0000F1), 4'b0111, 1);
        step(1'b1, mk(2, 0, 24'h0000F2), 4'b0111, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("preq_west_valid", 64'(out_valid), 64'b1000);
        rst = 1'b0;
        #1;
        chk("arst_valid_lit", 64'(out_valid), 64'h0);
        chk("arst_drop_lit",  64'(self_drop), 64'h0);
        chk("arst_ready_lit", 64'(in_ready), 64'h1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(1, 4'hF);
`ifdef NX_STREAM_DISTRIBUTOR_COUNT_EN
        chk("arst_count_lit", 64'(sent_count), 64'h0);
`endif
        step(1'b1, mk(3, 2, 24'h0AF7E4), 4'h0, 1);
        #1;
        chk("post_rst_south", 64'(out_valid), 64'b0100);
        idle(2, 4'hF);

        // Randomized traffic, two node positions
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle(6, 4'hF);
                @(negedge clk);
                node_row = 4'd1;
                node_col = 4'd3;
            end
            step(($urandom_range(0, 3) != 0),
                 mk($urandom_range(0, 4), $urandom_range(0, 5), 24'($urandom)),
                 4'($urandom), -1);
        end
        idle(6, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
